// File: rtl/dma_pkg.sv
// Shared AHB encodings, FSM state encoding and burst-type helper for the DMA master.
package dma_pkg;
  localparam logic [10:0] KB_BOUNDARY = 11'd1024;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'b000,
    HB_INCR   = 3'b001,
    HB_INCR8  = 3'b101
  } hburst_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NSEQ  = 3'd1,
    S_SEQ   = 3'd2,
    S_LASTD = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  // A fixed-length burst may only be advertised when it stays inside one 1 KB page.
  function automatic hburst_e burst_type(input logic [9:0] start, input logic [2:0] size,
                                         input logic [10:0] beats);
    logic [10:0] span_end;
    span_end = {1'b0, start} + (beats << size);
    return (span_end <= KB_BOUNDARY) ? HB_INCR8 : HB_INCR;
  endfunction
endpackage

// File: rtl/tile_buffer.sv
// Tile buffer: 1 write port, 1 registered read port. The read register doubles as HWDATA.
module tile_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage array; contents intentionally survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Synchronous read; holds its value when not enabled so data survives wait states.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/ahb_dma_master.sv
// AHB-lite burst master: turns groups of generator beats into 8-beat bursts to/from the tile buffer.
module ahb_dma_master
  import dma_pkg::*;
#(
  parameter int BURST_LEN  = 8,
  parameter int TILE_BEATS = 64,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32
) (
  input  logic              I_HCLK,
  input  logic              I_HRESET,
  input  logic              I_BUSY,
  input  logic [ADDR_W-1:0] I_ADDR,
  input  logic [2:0]        I_SIZE,
  input  logic              I_WRITE,
  output logic              O_DMA_READY,
  output logic [ADDR_W-1:0] O_HADDR,
  output logic [1:0]        O_HTRANS,
  output logic              O_HWRITE,
  output logic [2:0]        O_HSIZE,
  output logic [2:0]        O_HBURST,
  output logic [DATA_W-1:0] O_HWDATA,
  input  logic [DATA_W-1:0] I_HRDATA,
  input  logic              I_HREADY,
  input  logic              I_HRESP,
  output logic              O_ERROR
);
  localparam int IDX_W  = $clog2(TILE_BEATS);
  localparam int BEAT_W = $clog2(BURST_LEN);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [2:0]        size_q, size_d;
  logic [2:0]        hburst_q, hburst_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic              dph_q, dph_d;      // a data phase is outstanding on the bus
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic [ADDR_W-1:0] inc;
  htrans_e           htrans;
  logic              addr_acc, data_done, data_err;

  // Transfer type is a pure function of the state register.
  always_comb begin
    htrans = HT_IDLE;
    if (state_q == S_NSEQ)     htrans = HT_NONSEQ;
    else if (state_q == S_SEQ) htrans = HT_SEQ;
  end

  assign inc       = ADDR_W'(1) << size_q;
  assign addr_acc  = ((state_q == S_NSEQ) || (state_q == S_SEQ)) && I_HREADY;
  assign data_done = dph_q && I_HREADY && !I_HRESP;
  assign data_err  = dph_q && I_HRESP;

  // Next-state: burst sequencing, address stepping, buffer index advance and error capture.
  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    size_d   = size_q;
    hburst_d = hburst_q;
    write_d  = write_q;
    err_d    = err_q;
    beat_d   = beat_q;
    rd_idx_d = rd_idx_q;
    wr_idx_d = wr_idx_q;
    dph_d    = I_HREADY ? addr_acc : dph_q;
    if (data_done) begin
      if (write_q) wr_idx_d = wr_idx_q + 1'b1;
      else         rd_idx_d = rd_idx_q + 1'b1;
    end
    case (state_q)
      S_IDLE: if (I_BUSY && !err_q) begin
        haddr_d  = I_ADDR;
        size_d   = (I_SIZE > 3'd2) ? 3'd2 : I_SIZE;
        write_d  = I_WRITE;
        hburst_d = burst_type(I_ADDR[9:0], size_d, 11'(BURST_LEN));
        beat_d   = '0;
        state_d  = S_NSEQ;
      end
      S_NSEQ: if (I_HREADY) begin
        haddr_d = haddr_q + inc;
        beat_d  = BEAT_W'(1);
        state_d = S_SEQ;
      end
      S_SEQ: if (I_HREADY) begin
        if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
          state_d = S_LASTD;
        end else begin
          haddr_d = haddr_q + inc;
          beat_d  = beat_q + 1'b1;
        end
      end
      S_LASTD: if (I_HREADY) state_d = S_IDLE;
      default: ;
    endcase
    // First cycle of an error response: abandon the burst so the next cycle shows IDLE.
    if (data_err) begin
      state_d = S_ERR;
      err_d   = 1'b1;
      dph_d   = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge I_HCLK) begin
    if (I_HRESET) begin
      state_q  <= S_IDLE;
      haddr_q  <= '0;
      size_q   <= '0;
      hburst_q <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      dph_q    <= 1'b0;
      beat_q   <= '0;
      rd_idx_q <= '0;
      wr_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      size_q   <= size_d;
      hburst_q <= hburst_d;
      write_q  <= write_d;
      err_q    <= err_d;
      dph_q    <= dph_d;
      beat_q   <= beat_d;
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
    end
  end

  // Read port fetches the beat whose address is being accepted; when the previous
  // data phase completes in the same cycle, that beat is one index ahead of wr_idx.
  tile_buffer #(.DATA_W(DATA_W), .DEPTH(TILE_BEATS)) u_buf (
    .clk_i   (I_HCLK),
    .rst_i   (I_HRESET),
    .we_i    (data_done && !write_q && !I_HRESET),
    .waddr_i (rd_idx_q),
    .wdata_i (I_HRDATA),
    .re_i    (addr_acc && write_q),
    .raddr_i (wr_idx_q + IDX_W'(dph_q)),
    .rdata_o (O_HWDATA)
  );

  assign O_HTRANS    = htrans;
  assign O_DMA_READY = addr_acc;
  assign O_HADDR     = haddr_q;
  assign O_HWRITE    = write_q;
  assign O_HSIZE     = size_q;
  assign O_HBURST    = hburst_q;
  assign O_ERROR     = err_q;
endmodule
